// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: load-use/RAW interlock, forwarding select, mul/div scoreboard, flush control and perf counters.
module hazard_scoreboard #(
  parameter int NREG     = 32,
  parameter int REG_W    = 5,
  parameter int FWD_EN   = 1,
  parameter int MC_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_mc,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_mc_issue,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mc_done,
  input  logic [REG_W-1:0] mc_rd,
  input  logic             branch_taken,
  input  logic             jal_taken,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic [NREG-1:0]  sb_pending,
  output logic [2:0]       mc_count,
  output logic             sb_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [1:0] forwarding_none  = 2'd0;
  localparam logic [1:0] forwarding_typeA = 2'd1;
  localparam logic [1:0] forwarding_typeB = 2'd2;
  localparam int NX = 2**REG_W;
  function automatic logic hit(input logic [REG_W-1:0] src, input logic use_src, input logic we,
                               input logic [REG_W-1:0] rd);
    return use_src && we && rd != '0 && rd == src;
  endfunction
  function automatic logic [1:0] fsel(input logic [REG_W-1:0] src);
    return (FWD_EN == 0) ? forwarding_none :
           hit(src, 1'b1, mem_reg_write, mem_rd) ? forwarding_typeA :
           hit(src, 1'b1, wb_reg_write, wb_rd) ? forwarding_typeB : forwarding_none;
  endfunction
  logic [NX-1:0] pend_x, pend_nx;
  logic ld_use, sb_raw, struct_haz, ilk, flush, full, iss_ok, done_ok, err_now;
  // Widened view so any REG_W index is safe even when NREG < 2^REG_W.
  assign pend_x = NX'(sb_pending);
  assign ld_use = ex_mem_read && (hit(id_rs1, id_use_rs1, ex_reg_write, ex_rd) ||
                                  hit(id_rs2, id_use_rs2, ex_reg_write, ex_rd));
  // Issue in EX has not reached the scoreboard yet, so catch it directly.
  assign sb_raw = (id_use_rs1 && pend_x[id_rs1]) || (id_use_rs2 && pend_x[id_rs2]) ||
                  hit(id_rs1, id_use_rs1, ex_mc_issue, ex_rd) || hit(id_rs2, id_use_rs2, ex_mc_issue, ex_rd);
  assign struct_haz = id_is_mc && ({1'b0, mc_count} + 4'(ex_mc_issue) >= 4'(MC_DEPTH));
  assign ilk = (FWD_EN == 0) &&
               (hit(id_rs1, id_use_rs1, ex_reg_write, ex_rd) || hit(id_rs2, id_use_rs2, ex_reg_write, ex_rd) ||
                hit(id_rs1, id_use_rs1, mem_reg_write, mem_rd) || hit(id_rs2, id_use_rs2, mem_reg_write, mem_rd) ||
                hit(id_rs1, id_use_rs1, wb_reg_write, wb_rd) || hit(id_rs2, id_use_rs2, wb_reg_write, wb_rd));
  assign flush = branch_taken || jal_taken;
  assign flush_if_id = flush;
  assign flush_id_ex = flush;
  assign stall = !flush && (ld_use || sb_raw || struct_haz || ilk);
  assign forward_a = fsel(ex_rs1);
  assign forward_b = fsel(ex_rs2);
  // Illegal issue/done events are flagged and otherwise ignored.
  assign full    = mc_count == 3'(MC_DEPTH);
  assign iss_ok  = ex_mc_issue && !full;
  assign done_ok = mc_done && mc_count != '0 && pend_x[mc_rd];
  assign err_now = (mc_done && !done_ok) || (ex_mc_issue && full);
  always_comb begin
    pend_nx = pend_x;
    if (done_ok) pend_nx[mc_rd] = 1'b0;
    if (iss_ok && ex_rd != '0) pend_nx[ex_rd] = 1'b1;
    pend_nx[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sb_pending <= '0;
      mc_count   <= '0;
      sb_err     <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      sb_pending <= pend_nx[NREG-1:0];
      mc_count   <= mc_count + 3'(iss_ok) - 3'(done_ok);
      sb_err     <= sb_err || err_now;
      stall_cnt  <= cnt_clr ? '0 : (stall && !(&stall_cnt)) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt  <= cnt_clr ? '0 : (flush && !(&flush_cnt)) ? flush_cnt + 1'b1 : flush_cnt;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scoreboard-queue bench for hazard_scoreboard (forwarding and interlock-only builds).
module tb_hazard_scoreboard;
  logic clk, rstn;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, mc_rd;
  logic id_use_rs1, id_use_rs2, id_is_mc, ex_reg_write, ex_mem_read, ex_mc_issue;
  logic mem_reg_write, wb_reg_write, mc_done, branch_taken, jal_taken, cnt_clr;
  logic stall, flush_if_id, flush_id_ex, sb_err;
  logic [1:0] forward_a, forward_b;
  logic [31:0] sb_pending;
  logic [2:0] mc_count;
  logic [3:0] stall_cnt, flush_cnt;
  logic n_stall, n_fi, n_fe, n_err;
  logic [1:0] n_fa, n_fb;
  logic [31:0] n_pend;
  logic [2:0] n_cnt;
  logic [3:0] n_scnt, n_fcnt;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;

  hazard_scoreboard #(.CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_is_mc(id_is_mc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mc_issue(ex_mc_issue),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mc_done(mc_done), .mc_rd(mc_rd), .branch_taken(branch_taken), .jal_taken(jal_taken),
    .cnt_clr(cnt_clr), .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .forward_a(forward_a), .forward_b(forward_b), .sb_pending(sb_pending), .mc_count(mc_count),
    .sb_err(sb_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_scoreboard #(.FWD_EN(0), .CNT_W(4)) dut_ilk (
    .clk(clk), .rstn(rstn), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_is_mc(id_is_mc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mc_issue(ex_mc_issue),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .mc_done(mc_done), .mc_rd(mc_rd), .branch_taken(branch_taken), .jal_taken(jal_taken),
    .cnt_clr(cnt_clr), .stall(n_stall), .flush_if_id(n_fi), .flush_id_ex(n_fe),
    .forward_a(n_fa), .forward_b(n_fb), .sb_pending(n_pend), .mc_count(n_cnt),
    .sb_err(n_err), .stall_cnt(n_scnt), .flush_cnt(n_fcnt));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic want(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL queue_empty observed=%0h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd, mc_rd} = '0;
    {id_use_rs1, id_use_rs2, id_is_mc, ex_reg_write, ex_mem_read, ex_mc_issue} = '0;
    {mem_reg_write, wb_reg_write, mc_done, branch_taken, jal_taken, cnt_clr} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  initial begin
    rstn = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    want("rst_stall", 0); want("rst_flush", 0); want("rst_fwd_a", 0); want("rst_fwd_b", 0);
    want("rst_mc_count", 0); want("rst_pending", 0); want("rst_err", 0);
    @(negedge clk);
    got(stall); got(flush_if_id); got(forward_a); got(forward_b); got(mc_count); got(sb_pending); got(sb_err);

    step(); load_use();
    want("lu_stall", 1); want("lu_cnt0", 0);
    @(negedge clk); got(stall); got(stall_cnt);
    step(); idle();
    want("lu_release", 0); want("lu_cnt1", 1);
    @(negedge clk); got(stall); got(stall_cnt);
    step(); load_use(); ex_rd = 0; id_rs1 = 0;
    want("lu_x0", 0);
    @(negedge clk); got(stall);

    step(); idle(); ex_rs1 = 3; ex_rs2 = 3; mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
    want("fwd_a_typeA", 1); want("fwd_b_typeA", 1);
    @(negedge clk); got(forward_a); got(forward_b);
    step(); mem_reg_write = 0;
    want("fwd_a_typeB", 2);
    @(negedge clk); got(forward_a);
    step(); mem_reg_write = 1; id_rs1 = 3; id_use_rs1 = 1;
    want("ilk_stall", 1); want("ilk_fwd_none", 0); want("fwd_no_stall", 0);
    @(negedge clk); got(n_stall); got(n_fa); got(stall);

    step(); idle(); ex_mc_issue = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1;
    want("sb_issue_stall", 1);
    @(negedge clk); got(stall);
    step(); ex_mc_issue = 0;
    want("sb_pend9", 32'h200); want("sb_hold", 1); want("sb_count1", 1);
    @(negedge clk); got(sb_pending); got(stall); got(mc_count);
    step(); mc_done = 1; mc_rd = 9;
    want("sb_done_cycle", 1);
    @(negedge clk); got(stall);
    step(); mc_done = 0;
    want("sb_after_done", 0); want("sb_clear", 0); want("sb_count0", 0);
    @(negedge clk); got(stall); got(sb_pending); got(mc_count);

    step(); idle(); ex_mc_issue = 1; ex_rd = 4; id_is_mc = 1;
    want("st_first", 0);
    @(negedge clk); got(stall);
    step(); ex_rd = 6;
    want("st_second", 1);
    @(negedge clk); got(stall);
    step(); ex_mc_issue = 0;
    want("st_full", 1); want("st_count2", 2); want("st_pend", 32'h50);
    @(negedge clk); got(stall); got(mc_count); got(sb_pending);
    step(); mc_done = 1; mc_rd = 4;
    want("st_done_cycle", 1);
    @(negedge clk); got(stall);
    step(); mc_done = 0;
    want("st_release", 0); want("st_count1", 1);
    @(negedge clk); got(stall); got(mc_count);
    step(); id_is_mc = 0; ex_mc_issue = 1; ex_rd = 7; mc_done = 1; mc_rd = 6;
    step(); mc_rd = 7;
    want("iss_done_count", 1); want("iss_done_pend", 32'h80);
    @(negedge clk); got(mc_count); got(sb_pending);
    step(); ex_mc_issue = 0;
    want("same_reg_count", 1); want("same_reg_set", 32'h80);
    @(negedge clk); got(mc_count); got(sb_pending);
    step(); idle();
    want("drain_count", 0); want("drain_pend", 0); want("no_err", 0);
    @(negedge clk); got(mc_count); got(sb_pending); got(sb_err);

    step(); load_use(); branch_taken = 1;
    want("fl_stall", 0); want("fl_if_id", 1); want("fl_id_ex", 1); want("fl_cnt0", 0);
    @(negedge clk); got(stall); got(flush_if_id); got(flush_id_ex); got(flush_cnt);
    step(); idle();
    want("fl_cnt1", 1); want("fl_off", 0);
    @(negedge clk); got(flush_cnt); got(flush_if_id);

    step(); mc_done = 1; mc_rd = 3;
    step(); idle();
    want("err_set", 1); want("err_count0", 0);
    @(negedge clk); got(sb_err); got(mc_count);

    step(); load_use();
    repeat (20) @(posedge clk);
    want("sat_cnt", 15);
    @(negedge clk); got(stall_cnt);
    step(); cnt_clr = 1;
    step(); idle();
    want("clr_cnt", 0);
    @(negedge clk); got(stall_cnt);

    step(); ex_mc_issue = 1; ex_rd = 9; branch_taken = 1;
    step(); idle();
    want("pre_rst_count", 1);
    @(negedge clk); got(mc_count);
    step();
    #2 rstn = 0;
    #1;
    want("arst_count", 0); want("arst_pend", 0); want("arst_err", 0); want("arst_fcnt", 0); want("arst_scnt", 0);
    got(mc_count); got(sb_pending); got(sb_err); got(flush_cnt); got(stall_cnt);
    rstn = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
